// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: ID-stage forwarding-select and hazard control.
// Keeps a shadow copy of the EX/MEM destination state so only ID decode
// fields are needed. Detects load-use hazards and, with FWD_HAZARD_MDU_EN
// defined, holds the pipeline for a multi-cycle MDU op.
// Build macro: FWD_HAZARD_MDU_EN (undefined: no MDU handshake, ld stall only).
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_id_rs/i_id_rt/i_id_rn       ID register fields (5 bit)
//   i_id_use_rs/i_id_use_rt       ID instruction reads rs/rt
//   i_id_wreg/i_id_m2reg          ID instruction writes a reg / is a load
//   i_id_mdu, i_mdu_done          MDU op in ID, MDU result-ready pulse
//   i_branch_taken                branch resolved taken in ID
//   o_fwda/o_fwdb                 operand mux selects (00 rf,01 EX,10 MEM ALU,11 MEM load)
//   o_wpcir, o_bubble, o_flush_if pipeline freeze, ID/EX bubble, IF/ID kill
//   o_mdu_start                   one-cycle MDU launch
module fwd_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic       i_id_wreg,
  input  logic       i_id_m2reg,
  input  logic [4:0] i_id_rn,
  input  logic       i_id_mdu,
  input  logic       i_branch_taken,
  input  logic       i_mdu_done,
  output logic [1:0] o_fwda,
  output logic [1:0] o_fwdb,
  output logic       o_wpcir,
  output logic       o_bubble,
  output logic       o_flush_if,
  output logic       o_mdu_start
);

  localparam int unsigned RW = 5;

  logic          r_ex_wreg, r_ex_m2reg, r_mem_wreg, r_mem_m2reg;
  logic [RW-1:0] r_ex_rn, r_mem_rn;

  logic       w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;
  logic [1:0] w_fwda, w_fwdb;
  logic       w_ld_stall, w_mdu_stall, w_mdu_start, w_stall;

  // Register 0 never matches: it is hardwired zero.
  assign w_ex_hit_a  = r_ex_wreg  & (r_ex_rn  == i_id_rs) & (i_id_rs != RW'(0));
  assign w_ex_hit_b  = r_ex_wreg  & (r_ex_rn  == i_id_rt) & (i_id_rt != RW'(0));
  assign w_mem_hit_a = r_mem_wreg & (r_mem_rn == i_id_rs) & (i_id_rs != RW'(0));
  assign w_mem_hit_b = r_mem_wreg & (r_mem_rn == i_id_rt) & (i_id_rt != RW'(0));

  assign w_ld_stall = r_ex_m2reg & ((i_id_use_rs & w_ex_hit_a) |
                                    (i_id_use_rt & w_ex_hit_b));

  // Forward select; a load in EX selects regfile since the stall covers it.
  always_comb begin
    w_fwda = 2'b00;
    w_fwdb = 2'b00;
    if (i_id_use_rs) begin
      if (w_ex_hit_a)       w_fwda = r_ex_m2reg  ? 2'b00 : 2'b01;
      else if (w_mem_hit_a) w_fwda = r_mem_m2reg ? 2'b11 : 2'b10;
    end
    if (i_id_use_rt) begin
      if (w_ex_hit_b)       w_fwdb = r_ex_m2reg  ? 2'b00 : 2'b01;
      else if (w_mem_hit_b) w_fwdb = r_mem_m2reg ? 2'b11 : 2'b10;
    end
  end

`ifdef FWD_HAZARD_MDU_EN
  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_RELEASE} state_t;
  state_t r_state, w_state_nxt;

  // MDU sequencing; a pending load-use stall always takes precedence.
  always_comb begin
    w_state_nxt = r_state;
    w_mdu_stall = 1'b0;
    w_mdu_start = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!w_ld_stall && i_id_mdu) begin
          w_mdu_start = 1'b1;
          w_mdu_stall = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_mdu_stall = 1'b1;
        if (i_mdu_done) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!w_ld_stall) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end
`else
  logic w_unused_mdu;
  assign w_unused_mdu = i_id_mdu ^ i_mdu_done;
  assign w_mdu_stall  = 1'b0;
  assign w_mdu_start  = 1'b0;
`endif

  assign w_stall = w_ld_stall | w_mdu_stall;

  // Shadow EX/MEM destination state; the back end never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_wreg   <= 1'b0;
      r_ex_m2reg  <= 1'b0;
      r_ex_rn     <= '0;
      r_mem_wreg  <= 1'b0;
      r_mem_m2reg <= 1'b0;
      r_mem_rn    <= '0;
    end else begin
      r_ex_wreg   <= i_id_wreg  & ~w_stall;
      r_ex_m2reg  <= i_id_m2reg & ~w_stall;
      r_ex_rn     <= i_id_rn;
      r_mem_wreg  <= r_ex_wreg;
      r_mem_m2reg <= r_ex_m2reg;
      r_mem_rn    <= r_ex_rn;
    end
  end

  // Outputs are forced to their idle values for as long as rst is high.
  assign o_fwda      = rst ? 2'b00 : w_fwda;
  assign o_fwdb      = rst ? 2'b00 : w_fwdb;
  assign o_wpcir     = rst | ~w_stall;
  assign o_bubble    = ~rst & w_stall;
  assign o_flush_if  = ~rst & i_branch_taken & ~w_stall;
  assign o_mdu_start = ~rst & w_mdu_start;

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline control block that sequences the ID-stage operand-forwarding multiplexers (4-input, 32-bit, 2-bit select) and the pipeline freeze/bubble/flush controls. It keeps a shadow copy of the EX and MEM destination-register state, so it needs only ID-stage decode fields. It detects load-use hazards and, when enabled, holds the pipeline for a multi-cycle multiply/divide unit (MDU). It sits beside the decoder in the ID stage and drives the forwarding mux selects, the PC/IF-ID write enable and the ID/EX bubble.

## Interface
- No parameters. Register index width is fixed at 5 bits; register 0 is hardwired zero.
- clk  in  1  pipeline clock; rising edge
- rst  in  1  asynchronous reset, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_wreg  in  1  ID instruction writes a register
- id_m2reg  in  1  ID instruction is a load (result comes from memory)
- id_rn  in  5  destination register of the ID instruction (after rt/rd/ra selection)
- id_mdu  in  1  ID instruction is a multi-cycle MDU op
- branch_taken  in  1  branch resolved taken in ID this cycle
- mdu_done  in  1  MDU result ready (single-cycle pulse)
- fwda  out  2  select for operand-A mux: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
- fwdb  out  2  same encoding, for operand B
- wpcir  out  1  PC and IF/ID write enable; 0 = freeze
- bubble  out  1  force ID/EX control fields to NOP
- flush_if  out  1  kill the IF/ID instruction
- mdu_start  out  1  one-cycle MDU launch pulse

## Operation
- Shadow registers ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn are updated every clock. The back end never stalls.
  - EX <= ID fields, with wreg and m2reg forced to 0 when bubble=1.
  - MEM <= EX.
- Match rule: match_ex(r) = ex_wreg & (ex_rn==r) & (r!=0). match_mem(r) is defined the same way with the mem_* registers.
- Forwarding for each operand, with r = rs (A) or rt (B), in priority order:
  1. match_ex & ~ex_m2reg -> 01.
  2. match_ex & ex_m2reg -> 00 (a stall is in force).
  3. match_mem -> 11 if mem_m2reg, otherwise 10.
  4. Otherwise 00.
  - Unused operands (id_use_* = 0) always select 00.
- Load-use stall: ld_stall = ex_m2reg & ((id_use_rs & match_ex(rs)) | (id_use_rt & match_ex(rt))).
- FSM states RUN, WAIT, RELEASE; reset state RUN.
  - RUN:
    - ld_stall -> stall, stay in RUN.
    - else id_mdu -> mdu_start=1, stall, go to WAIT.
    - else no stall.
  - WAIT: stall. mdu_done=1 -> RELEASE; otherwise stay in WAIT.
  - RELEASE: no MDU stall and id_mdu is ignored, so the MDU instruction advances. ld_stall is still honoured. Go to RUN next cycle, unless ld_stall holds, in which case stay in RELEASE.
- While stalled: wpcir=0, bubble=1.
- flush_if = branch_taken & ~stall. A taken branch seen during a stall is ignored; the decoder re-presents it.
- mdu_done outside WAIT is ignored.

## Timing
- fwda, fwdb, wpcir, bubble, flush_if and mdu_start are combinational from the ID inputs, the shadow registers and the FSM state, all valid within the same cycle.
- Shadow registers and FSM state update on the rising clk edge.
- Load-use costs exactly 1 stall cycle. On the following cycle the load is in MEM and the operand selects 11.
- MDU op: mdu_start in cycle T; stall lasts from T through the cycle in which mdu_done is sampled, plus the transition into RELEASE. The instruction advances in the RELEASE cycle.
- While rst=1:
  - FSM is forced to RUN and all shadow registers to 0.
  - Outputs are forced to fwda=fwdb=00, wpcir=1, bubble=0, flush_if=0, mdu_start=0.
- Reset during WAIT abandons the MDU op; the stall drops immediately.
- Simultaneous ld_stall and id_mdu: ld_stall wins and no mdu_start is issued. MDU issue retries the next cycle.

## Configuration
- Macro: FWD_HAZARD_MDU_EN.
- Defined: WAIT and RELEASE states exist; id_mdu and mdu_done are honoured as described under Operation.
- Undefined:
  - FSM reduces to RUN only; id_mdu and mdu_done are ignored.
  - mdu_start is tied to 0.
  - The stall condition is ld_stall alone.

## Test plan
- EX ALU forward:
  - Stimulus: EX holds add writing $5 (wreg=1, m2reg=0); ID reads rs=$5 with id_use_rs=1.
  - Required: fwda=01, wpcir=1, bubble=0.
  - Same case with rs=$0: fwda=00.
- Load-use:
  - Stimulus: EX holds lw writing $8; ID reads rt=$8.
  - Required: cycle 1 wpcir=0, bubble=1, fwdb=00. Cycle 2 fwdb=11, wpcir=1.
- EX/MEM priority:
  - Stimulus: MEM and EX both write $3 via ALU ops.
  - Required: fwda=01. After EX's value retires into MEM, fwda=10.
- MDU (macro defined):
  - Stimulus: id_mdu=1 at T; mdu_done at T+4.
  - Required: mdu_start high only at T. wpcir=0 from T to T+4. RELEASE at T+5 with wpcir=1. RUN at T+6.
- Branch during stall:
  - Stimulus: branch_taken=1 while ld_stall=1.
  - Required: flush_if=0.
  - Next cycle, branch_taken=1 with no stall: flush_if=1.
- Reset in WAIT:
  - Stimulus: assert rst asynchronously mid-WAIT.
  - Required: wpcir=1 and bubble=0 immediately. Shadow registers read 0 after release.
